instr_decode_sequencer: RTL and testbench

//  Multi-cycle control front end directly upstream of the ALU: steps the core through FETCH/EXEC1/EXEC2,

---
 rtl/instr_decode_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_instr_decode_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_sequencer.sv
// instr_decode_sequencer: multi-cycle control front end directly upstream of the ALU.
//
// What it does:
//   - Steps the core through FETCH -> EXEC1 -> EXEC2 -> FETCH.
//   - Latches the fetched word into the instruction register (IR) in FETCH.
//   - Decodes the IR combinationally into a 7-bit ALU op code, register
//     indices, shift amount and extended immediate.
//   - waitrequest freezes whichever state is current.
//   - halt_req (sampled when EXEC2 completes) parks the sequencer in HALTED
//     until reset.
//
// Optional build macro:
//   INVALID_HALT_EN  When defined, an unsupported encoding completing EXEC2
//                    halts the core exactly like halt_req. When undefined,
//                    it runs as a 3-cycle no-op.
//
// Handshake:
//   waitrequest is a busy flag from memory. While it is high, the current
//   state is held and nothing is latched. readdata is only consumed in FETCH
//   on a cycle where waitrequest is low.
//
// Debug:
//   state_dbg exposes the FSM state (0 FETCH, 1 EXEC1, 2 EXEC2, 3 HALTED).
module instr_decode_sequencer #(
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        halt_req,
  output logic        active,
  output logic        fetch,
  output logic        exec1,
  output logic        exec2,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic        invalid,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  sa,
  output logic [31:0] imm_ext,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_EXEC1  = 2'd1,
    S_EXEC2  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  // ALU op codes
  localparam logic [6:0] OP_NONE   = 7'd0;
  localparam logic [6:0] OP_ADD    = 7'd1;
  localparam logic [6:0] OP_ADDI   = 7'd2;
  localparam logic [6:0] OP_ADDIU  = 7'd3;
  localparam logic [6:0] OP_ADDU   = 7'd4;
  localparam logic [6:0] OP_AND    = 7'd5;
  localparam logic [6:0] OP_ANDI   = 7'd6;
  localparam logic [6:0] OP_DIV    = 7'd7;
  localparam logic [6:0] OP_DIVU   = 7'd8;
  localparam logic [6:0] OP_MFHI   = 7'd9;
  localparam logic [6:0] OP_MFLO   = 7'd10;
  localparam logic [6:0] OP_MTHI   = 7'd11;
  localparam logic [6:0] OP_MTLO   = 7'd12;
  localparam logic [6:0] OP_MULT   = 7'd13;
  localparam logic [6:0] OP_MULTU  = 7'd14;
  localparam logic [6:0] OP_OR     = 7'd15;
  localparam logic [6:0] OP_ORI    = 7'd16;
  localparam logic [6:0] OP_SLL    = 7'd17;
  localparam logic [6:0] OP_SLLV   = 7'd18;
  localparam logic [6:0] OP_SLT    = 7'd19;
  localparam logic [6:0] OP_SLTI   = 7'd20;
  localparam logic [6:0] OP_SLTIU  = 7'd21;
  localparam logic [6:0] OP_SLTU   = 7'd22;
  localparam logic [6:0] OP_SRA    = 7'd23;
  localparam logic [6:0] OP_SRAV   = 7'd24;
  localparam logic [6:0] OP_SRL    = 7'd25;
  localparam logic [6:0] OP_SRLV   = 7'd26;
  localparam logic [6:0] OP_SUBU   = 7'd27;
  localparam logic [6:0] OP_XOR    = 7'd28;
  localparam logic [6:0] OP_XORI   = 7'd29;
  localparam logic [6:0] OP_BEQ    = 7'd30;
  localparam logic [6:0] OP_BGEZ   = 7'd31;
  localparam logic [6:0] OP_BGEZAL = 7'd32;
  localparam logic [6:0] OP_BGTZ   = 7'd33;
  localparam logic [6:0] OP_BLEZ   = 7'd34;
  localparam logic [6:0] OP_BLTZ   = 7'd35;
  localparam logic [6:0] OP_BLTZAL = 7'd36;
  localparam logic [6:0] OP_BNE    = 7'd37;
  localparam logic [6:0] OP_J      = 7'd38;
  localparam logic [6:0] OP_JAL    = 7'd39;
  localparam logic [6:0] OP_JALR   = 7'd40;
  localparam logic [6:0] OP_JR     = 7'd41;
  localparam logic [6:0] OP_LB     = 7'd42;
  localparam logic [6:0] OP_LBU    = 7'd43;
  localparam logic [6:0] OP_LH     = 7'd44;
  localparam logic [6:0] OP_LHU    = 7'd45;
  localparam logic [6:0] OP_LUI    = 7'd46;
  localparam logic [6:0] OP_LW     = 7'd47;
  localparam logic [6:0] OP_LWL    = 7'd48;
  localparam logic [6:0] OP_LWR    = 7'd49;
  localparam logic [6:0] OP_SB     = 7'd50;
  localparam logic [6:0] OP_SH     = 7'd51;
  localparam logic [6:0] OP_SW     = 7'd52;

`ifdef INVALID_HALT_EN
  localparam logic HALT_ON_INVALID = 1'b1;
`else
  localparam logic HALT_ON_INVALID = 1'b0;
`endif

  state_t state;
  state_t state_next;
  logic   halt_now;

  // Field extraction: fixed bit positions regardless of instruction format
  assign rs        = instr[25:21];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign sa        = instr[10:6];
  assign state_dbg = state;

  // An EXEC2 completion stops the core on a PC-unit request or, when enabled, on a bad encoding
  assign halt_now = halt_req | (HALT_ON_INVALID & invalid);

  // Next-state selection; waitrequest holds FETCH/EXEC1/EXEC2, HALTED is absorbing
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (!waitrequest) state_next = S_EXEC1;
      S_EXEC1:  if (!waitrequest) state_next = S_EXEC2;
      S_EXEC2:  if (!waitrequest) state_next = halt_now ? S_HALTED : S_FETCH;
      default:  state_next = S_HALTED;
    endcase
  end

  // State register with registered one-hot strobes, active flag and IR load
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_FETCH;
      instr  <= RESET_INSTR;
      active <= 1'b1;
      fetch  <= 1'b1;
      exec1  <= 1'b0;
      exec2  <= 1'b0;
    end else begin
      state  <= state_next;
      active <= (state_next != S_HALTED);
      fetch  <= (state_next == S_FETCH);
      exec1  <= (state_next == S_EXEC1);
      exec2  <= (state_next == S_EXEC2);
      if (state == S_FETCH && !waitrequest) begin
        instr <= readdata;
      end
    end
  end

  // Opcode/funct/rt decode into the ALU op code; unlisted encodings leave op at 0
  always_comb begin
    op = OP_NONE;
    case (instr[31:26])
      6'h00: begin
        case (instr[5:0])
          6'h00: op = OP_SLL;
          6'h02: op = OP_SRL;
          6'h03: op = OP_SRA;
          6'h04: op = OP_SLLV;
          6'h06: op = OP_SRLV;
          6'h07: op = OP_SRAV;
          6'h08: op = OP_JR;
          6'h09: op = OP_JALR;
          6'h10: op = OP_MFHI;
          6'h11: op = OP_MTHI;
          6'h12: op = OP_MFLO;
          6'h13: op = OP_MTLO;
          6'h18: op = OP_MULT;
          6'h19: op = OP_MULTU;
          6'h1A: op = OP_DIV;
          6'h1B: op = OP_DIVU;
          6'h20: op = OP_ADD;
          6'h21: op = OP_ADDU;
          6'h23: op = OP_SUBU;
          6'h24: op = OP_AND;
          6'h25: op = OP_OR;
          6'h26: op = OP_XOR;
          6'h2A: op = OP_SLT;
          6'h2B: op = OP_SLTU;
          default: op = OP_NONE;
        endcase
      end
      6'h01: begin
        case (instr[20:16])
          5'h00: op = OP_BLTZ;
          5'h01: op = OP_BGEZ;
          5'h10: op = OP_BLTZAL;
          5'h11: op = OP_BGEZAL;
          default: op = OP_NONE;
        endcase
      end
      6'h02: op = OP_J;
      6'h03: op = OP_JAL;
      6'h04: op = OP_BEQ;
      6'h05: op = OP_BNE;
      6'h06: op = OP_BLEZ;
      6'h07: op = OP_BGTZ;
      6'h08: op = OP_ADDI;
      6'h09: op = OP_ADDIU;
      6'h0A: op = OP_SLTI;
      6'h0B: op = OP_SLTIU;
      6'h0C: op = OP_ANDI;
      6'h0D: op = OP_ORI;
      6'h0E: op = OP_XORI;
      6'h0F: op = OP_LUI;
      6'h20: op = OP_LB;
      6'h21: op = OP_LH;
      6'h22: op = OP_LWL;
      6'h23: op = OP_LW;
      6'h24: op = OP_LBU;
      6'h25: op = OP_LHU;
      6'h26: op = OP_LWR;
      6'h28: op = OP_SB;
      6'h29: op = OP_SH;
      6'h2B: op = OP_SW;
      default: op = OP_NONE;
    endcase
  end

  assign invalid = (op == OP_NONE);

  // Immediate extension: logical immediates zero-extend, LUI shifts up, everything else sign-extends
  always_comb begin
    imm_ext = {{16{instr[15]}}, instr[15:0]};
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: imm_ext = {16'h0000, instr[15:0]};
      OP_LUI:                   imm_ext = {instr[15:0], 16'h0000};
      default:                  imm_ext = {{16{instr[15]}}, instr[15:0]};
    endcase
  end

endmodule

// File: tb/tb_instr_decode_sequencer.sv
// Testbench for instr_decode_sequencer.
//
// A reference model runs alongside the DUT:
//   - sequencing is a phase counter 0..2 plus a halted flag;
//   - decoding is a lookup in (code, op) tables written straight from the
//     op-code listing.
// Every cycle all outputs are compared against that model. Directed steps
// come first, followed by a randomized run.
module tb_instr_decode_sequencer;

  logic        clk;
  logic        reset;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        halt_req;
  logic        active;
  logic        fetch;
  logic        exec1;
  logic        exec2;
  logic [31:0] instr;
  logic [6:0]  op;
  logic        invalid;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sa;
  logic [31:0] imm_ext;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_phase;   // 0 fetch, 1 exec1, 2 exec2
  bit          m_halted;
  logic [31:0] m_instr;

`ifdef INVALID_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  // {code, op} tables
  int special_tab[24][2] = '{
    '{'h00,17}, '{'h02,25}, '{'h03,23}, '{'h04,18}, '{'h06,26}, '{'h07,24},
    '{'h08,41}, '{'h09,40}, '{'h10,9},  '{'h11,11}, '{'h12,10}, '{'h13,12},
    '{'h18,13}, '{'h19,14}, '{'h1A,7},  '{'h1B,8},  '{'h20,1},  '{'h21,4},
    '{'h23,27}, '{'h24,5},  '{'h25,15}, '{'h26,28}, '{'h2A,19}, '{'h2B,22}};
  int regimm_tab[4][2] = '{'{'h00,35}, '{'h01,31}, '{'h10,36}, '{'h11,32}};
  int opcode_tab[24][2] = '{
    '{'h02,38}, '{'h03,39}, '{'h04,30}, '{'h05,37}, '{'h06,34}, '{'h07,33},
    '{'h08,2},  '{'h09,3},  '{'h0A,20}, '{'h0B,21}, '{'h0C,6},  '{'h0D,16},
    '{'h0E,29}, '{'h0F,46}, '{'h20,42}, '{'h21,44}, '{'h22,48}, '{'h23,47},
    '{'h24,43}, '{'h25,45}, '{'h26,49}, '{'h28,50}, '{'h29,51}, '{'h2B,52}};

  instr_decode_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .waitrequest (waitrequest),
    .readdata    (readdata),
    .halt_req    (halt_req),
    .active      (active),
    .fetch       (fetch),
    .exec1       (exec1),
    .exec2       (exec2),
    .instr       (instr),
    .op          (op),
    .invalid     (invalid),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .sa          (sa),
    .imm_ext     (imm_ext),
    .state_dbg   (state_dbg)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference decode by table lookup
  function automatic int ref_op(input logic [31:0] w);
    int r = 0;
    if (w[31:26] == 6'h00) begin
      foreach (special_tab[i]) if (special_tab[i][0] == int'(w[5:0])) r = special_tab[i][1];
    end else if (w[31:26] == 6'h01) begin
      foreach (regimm_tab[i]) if (regimm_tab[i][0] == int'(w[20:16])) r = regimm_tab[i][1];
    end else begin
      foreach (opcode_tab[i]) if (opcode_tab[i][0] == int'(w[31:26])) r = opcode_tab[i][1];
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    int o = ref_op(w);
    if (o == 6 || o == 16 || o == 29) return {16'h0, w[15:0]};
    if (o == 46) return {w[15:0], 16'h0};
    return {{16{w[15]}}, w[15:0]};
  endfunction

  // Random instruction: mostly legal encodings, some raw random words
  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 4))
      0: w[31:26] = 6'(opcode_tab[$urandom_range(0, 23)][0]);
      1: begin w[31:26] = 6'h00; w[5:0] = 6'(special_tab[$urandom_range(0, 23)][0]); end
      2: begin w[31:26] = 6'h01; w[20:16] = 5'(regimm_tab[$urandom_range(0, 3)][0]); end
      3: w[31:26] = 6'(opcode_tab[$urandom_range(0, 23)][0]);
      default: ;
    endcase
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output with the model
  task automatic check_all();
    logic [3:0] exp_str;
    int         o;
    o = ref_op(m_instr);
    if (m_halted) exp_str = 4'b0000;
    else exp_str = {1'b1, m_phase == 0, m_phase == 1, m_phase == 2};
    check("strobes", 32'({active, fetch, exec1, exec2}), 32'(exp_str));
    check("instr", instr, m_instr);
    check("op", 32'(op), 32'(o));
    check("invalid", 32'(invalid), 32'(o == 0));
    check("fields", {12'h0, rs, rt, rd, sa}, {12'h0, m_instr[25:6]});
    check("imm_ext", imm_ext, ref_imm(m_instr));
  endtask

  // Apply one cycle of inputs (called just after a negedge), advance the model, then check
  task automatic cycle(input bit rst, input bit wr, input logic [31:0] rdata, input bit hr);
    reset       = rst;
    waitrequest = wr;
    readdata    = rdata;
    halt_req    = hr;
    if (rst) begin
      m_phase = 0; m_halted = 0; m_instr = 32'h0;
    end else if (!m_halted && !wr) begin
      if (m_phase == 0) m_instr = rdata;
      if (m_phase == 2 && (hr || (HALT_EN && ref_op(m_instr) == 0))) m_halted = 1;
      m_phase = (m_phase + 1) % 3;
    end
    @(negedge clk);
    check_all();
  endtask

  // Cycles from a fetch strobe to the next, with k wait cycles in EXEC1
  task automatic measure(input int k);
    int n = 1;
    int waits = k;
    cycle(1, 0, 32'h0, 0);
    cycle(0, 0, 32'h012A4021, 0);
    while (fetch !== 1'b1 && n < 20) begin
      if (waits > 0) begin
        cycle(0, 1, 32'h0, 0);
        waits--;
      end else begin
        cycle(0, 0, 32'h0, 0);
      end
      n++;
    end
    check("cycles_per_instr", 32'(n), 32'(3 + k));
  endtask

  initial begin
    m_phase = 0; m_halted = 0; m_instr = 32'h0;

    // Reset state
    cycle(1, 0, 32'h0, 0);
    check("reset_op", 32'(op), 32'd17);

    // addu $8,$9,$10
    cycle(0, 0, 32'h012A4021, 0);
    check("addu_op", 32'(op), 32'd4);
    check("addu_rs", 32'(rs), 32'd9);
    check("addu_rt", 32'(rt), 32'd10);
    check("addu_rd", 32'(rd), 32'd8);

    // Reset mid-EXEC1
    cycle(1, 0, 32'h0, 0);
    check("rst_mid_exec1_fetch", 32'(fetch), 32'd1);
    check("rst_mid_exec1_instr", instr, 32'h0);

    // Immediate extension cases through full instruction cycles
    cycle(0, 0, 32'h3C041234, 0);
    check("lui_imm", imm_ext, 32'h12340000);
    cycle(0, 0, 32'h0, 0);
    cycle(0, 0, 32'h0, 0);
    cycle(0, 0, 32'h2402FFFF, 0);
    check("addiu_imm", imm_ext, 32'hFFFFFFFF);
    cycle(0, 0, 32'h0, 0);
    cycle(0, 0, 32'h0, 0);
    cycle(0, 0, 32'h3402FFFF, 0);
    check("ori_imm", imm_ext, 32'h0000FFFF);
    cycle(0, 0, 32'h0, 0);
    cycle(0, 0, 32'h0, 0);

    // Wait cycles stretch the instruction by one cycle each
    for (int k = 0; k < 4; k++) measure(k);

    // Halt request held off by waitrequest in EXEC2
    cycle(1, 0, 32'h0, 0);
    cycle(0, 0, 32'h00000000, 0);
    cycle(0, 0, 32'h0, 0);
    cycle(0, 1, 32'h0, 1);
    check("halt_held_exec2", 32'(exec2), 32'd1);
    cycle(0, 0, 32'h0, 1);
    check("halted_active", 32'(active), 32'd0);
    cycle(0, 0, 32'h3C041234, 0);
    check("halted_instr_frozen", instr, 32'h0);
    cycle(1, 0, 32'h0, 0);
    check("reset_from_halt", 32'(fetch), 32'd1);

    // Invalid encoding runs to EXEC2 then halts or returns to FETCH depending on build
    cycle(0, 0, 32'hFC000000, 0);
    check("invalid_flag", 32'(invalid), 32'd1);
    cycle(0, 0, 32'h0, 0);
    cycle(0, 0, 32'h0, 0);
    check("invalid_after_exec2", 32'({active, fetch}), HALT_EN ? 32'd0 : 32'd3);

    // Randomized run
    cycle(1, 0, 32'h0, 0);
    for (int i = 0; i < 2000; i++) begin
      if (m_halted) begin
        cycle($urandom_range(0, 3) == 0, $urandom_range(0, 1), rand_instr(), $urandom_range(0, 1));
      end else begin
        cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, rand_instr(),
              $urandom_range(0, 7) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
